// File: rtl/zicntr_counter_bank.sv
// Zicntr/Zihpm-lite counter bank: 64-bit cycle/instret counters, mcountinhibit,
// and the CSR read/write port serving them with a one-cycle registered read.
module zicntr_counter_bank #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            InstructionRetired,
    input  logic [11:0]     CsrAddr,
    input  logic            CsrReadEn,
    input  logic            CsrWriteEn,
    input  logic [XLEN-1:0] CsrWriteData,
    output logic [XLEN-1:0] CsrReadData,
    output logic            CsrReadValid,
    output logic            CsrIllegal,
    output logic [63:0]     CycleCSRValue,
    output logic [63:0]     InsretCSRValue
);

    localparam bit HAS_H = (XLEN == 32);

    logic [63:0]     cycle_q, instret_q;
    logic [63:0]     cycle_next, instret_next;
    logic            inh_cy, inh_ir;
    logic            sel_cyc_ro, sel_cych_ro, sel_ins_ro, sel_insh_ro;
    logic            sel_mcycle, sel_mcycleh, sel_minstret, sel_minstreth, sel_inhibit;
    logic            mapped, access, illegal, wr_ok;
    logic [XLEN-1:0] rdata;

    always_comb begin
        sel_cyc_ro    = 1'b0;
        sel_cych_ro   = 1'b0;
        sel_ins_ro    = 1'b0;
        sel_insh_ro   = 1'b0;
        sel_mcycle    = 1'b0;
        sel_mcycleh   = 1'b0;
        sel_minstret  = 1'b0;
        sel_minstreth = 1'b0;
        sel_inhibit   = 1'b0;
        case (CsrAddr)
            12'hC00, 12'hC01: sel_cyc_ro    = 1'b1;
            12'hC02:          sel_ins_ro    = 1'b1;
            12'hC80, 12'hC81: sel_cych_ro   = HAS_H;
            12'hC82:          sel_insh_ro   = HAS_H;
            12'hB00:          sel_mcycle    = 1'b1;
            12'hB02:          sel_minstret  = 1'b1;
            12'hB80:          sel_mcycleh   = HAS_H;
            12'hB82:          sel_minstreth = HAS_H;
            12'h320:          sel_inhibit   = 1'b1;
            default: ;
        endcase
    end

    // The whole 0xCxx block is read-only, so a write there is illegal even if mapped.
    assign mapped  = sel_cyc_ro | sel_cych_ro | sel_ins_ro | sel_insh_ro | sel_mcycle
                   | sel_mcycleh | sel_minstret | sel_minstreth | sel_inhibit;
    assign access  = CsrReadEn | CsrWriteEn;
    assign illegal = access & (~mapped | (CsrWriteEn & (CsrAddr[11:8] == 4'hC)));
    assign wr_ok   = CsrWriteEn & ~illegal;

    always_comb begin
        rdata = '0;
        if (sel_cyc_ro | sel_mcycle)
            rdata = XLEN'(cycle_q);
        else if (sel_cych_ro | sel_mcycleh)
            rdata = XLEN'(cycle_q[63:32]);
        else if (sel_ins_ro | sel_minstret)
            rdata = XLEN'(instret_q);
        else if (sel_insh_ro | sel_minstreth)
            rdata = XLEN'(instret_q[63:32]);
        else if (sel_inhibit)
            rdata = XLEN'({inh_ir, 1'b0, inh_cy});
    end

    // A half-write replaces that half and suppresses the increment for the cycle.
    function automatic logic [63:0] next_count(
        input logic [63:0]     cur,
        input logic            wr_lo,
        input logic            wr_hi,
        input logic [XLEN-1:0] wd,
        input logic            inhibit,
        input logic            inc
    );
        logic [63:0] r;
        if (wr_lo)
            r = HAS_H ? {cur[63:32], wd[31:0]} : 64'(wd);
        else if (wr_hi)
            r = {wd[31:0], cur[31:0]};
        else if (!inhibit)
            r = cur + 64'(inc);
        else
            r = cur;
        return r;
    endfunction

    assign cycle_next   = next_count(cycle_q, wr_ok & sel_mcycle, wr_ok & sel_mcycleh,
                                     CsrWriteData, inh_cy, 1'b1);
    assign instret_next = next_count(instret_q, wr_ok & sel_minstret, wr_ok & sel_minstreth,
                                     CsrWriteData, inh_ir, InstructionRetired);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_q      <= '0;
            instret_q    <= '0;
            inh_cy       <= 1'b0;
            inh_ir       <= 1'b0;
            CsrReadData  <= '0;
            CsrReadValid <= 1'b0;
            CsrIllegal   <= 1'b0;
        end else begin
            cycle_q      <= cycle_next;
            instret_q    <= instret_next;
            if (wr_ok && sel_inhibit) begin
                inh_cy <= CsrWriteData[0];
                inh_ir <= CsrWriteData[2];
            end
            CsrReadValid <= CsrReadEn & ~illegal;
            CsrIllegal   <= illegal;
            if (illegal)
                CsrReadData <= '0;
            else if (CsrReadEn)
                CsrReadData <= rdata;
        end
    end

    assign CycleCSRValue  = cycle_q;
    assign InsretCSRValue = instret_q;

endmodule

// File: doc/zicntr_counter_bank.md
# zicntr_counter_bank

Architectural state holder for the Zicntr/Zihpm-lite counters: it owns the 64-bit cycle and instret registers plus `mcountinhibit`. It advances them every clock from the retire pulse, and serves CSR reads and machine-mode writes from the computational-stage CSR unit. Its `CycleCSRValue`/`InsretCSRValue` outputs feed the ZICNTR control-struct generator, which computes next values and exposes the read-only `cycle`/`time`/`instret` views.

## Interface
- `XLEN`, 32, register width (32 or 64); selects whether high-half CSRs exist.
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- `InstructionRetired`  in  1  one pulse per retired instruction, sampled every cycle.
- `CsrAddr`  in  12  CSR address of the current access.
- `CsrReadEn`  in  1  read request this cycle.
- `CsrWriteEn`  in  1  write request this cycle (may coincide with `CsrReadEn` = csrrw).
- `CsrWriteData`  in  XLEN  write value (already merged for csrrs/csrrc).
- `CsrReadData`  out  XLEN  registered read result.
- `CsrReadValid`  out  1  registered; high the cycle after an accepted access with `CsrReadEn`.
- `CsrIllegal`  out  1  registered; high the cycle after any illegal access.
- `CycleCSRValue`  out  64  current cycle counter.
- `InsretCSRValue`  out  64  current instret counter.

## Operation
- Address map:
  - Read-only: `cycle` 0xC00, `time` 0xC01 (mirrors cycle), `instret` 0xC02.
  - Read/write: `mcycle` 0xB00, `minstret` 0xB02, `mcountinhibit` 0x320 (only bits 0 CY and 2 IR implemented; other bits read 0, writes ignored).
  - XLEN=32 only: `cycleh` 0xC80, `timeh` 0xC81, `instreth` 0xC82, `mcycleh` 0xB80, `minstreth` 0xB82; these return bits [63:32].
- Low-half reads return bits [XLEN-1:0].
- Illegal, flagged on `CsrIllegal`:
  - any write to a 0xCxx address;
  - any unmapped address with read or write enabled;
  - h-addresses when XLEN=64.
  - An illegal access returns `CsrReadData`=0 and causes no state change.
- Cycle update, per cycle:
  - a legal write to `mcycle`/`mcycleh` sets that half to `CsrWriteData` and leaves the other half unchanged, with no increment;
  - else, if CY=0, increment by 1;
  - else, hold.
- Instret update: same rules using `minstret`/`minstreth`, IR, and increment by `InstructionRetired`. A write wins over a coincident retire pulse, which is dropped.
- All arithmetic is 64-bit modulo 2^64. 0xFFFF_FFFF_FFFF_FFFF+1 = 0. On XLEN=32 the carry from the low to the high half propagates in the same cycle.
- A `mcountinhibit` write takes effect from the next cycle; the write cycle itself uses the old inhibit bits.
- Read+write on the same address in the same cycle returns the pre-write value.

## Timing
- Reset values:
  - both counters 0;
  - `mcountinhibit` 0;
  - `CsrReadData` 0;
  - `CsrReadValid` 0;
  - `CsrIllegal` 0.
- First increment is visible the cycle after `reset` deasserts.
- `CycleCSRValue`/`InsretCSRValue` are flop outputs and change only on the clock edge.
- Read latency is 1 cycle. `CsrReadData` holds the counter value as of the request cycle (pre-update), so a read of `cycle` at cycle N returns the value seen on `CycleCSRValue` at N.
- `CsrReadValid`/`CsrIllegal` are single-cycle pulses. `CsrReadData` holds its last value when `CsrReadValid`=0.
- Back-to-back accesses are accepted every cycle; there is no stall or backpressure.
- `reset` mid-operation clears all state on that edge. A read issued in the reset cycle produces no `CsrReadValid`.

## Test plan
- **Reset then free-run:** reset 1 cycle, then idle 10 cycles → `CycleCSRValue`=10, `InsretCSRValue`=0, outputs 0 during reset.
- **Retire pulses plus read:**
  - Stimulus: `InstructionRetired` high for 5 of 8 cycles, then read 0xC02.
  - Response: next-cycle `CsrReadValid`=1, `CsrReadData`=5.
  - Also: 0xC01 reads equal 0xC00 reads.
- **Write priority and wrap:**
  - write `mcycle`=0xFFFF_FFFF (XLEN=32) with `mcycleh`=0xFFFF_FFFF → next cycle 0xFFFF_FFFF_FFFF_FFFF, following cycle 0;
  - write `minstret`=7 coincident with a retire pulse → 7, not 8.
- **Low-to-high carry (XLEN=32):** set `mcycle`=0xFFFF_FFFE, `mcycleh`=3 → two cycles later `cycleh` reads 4 and `cycle` reads 0.
- **Inhibit:**
  - write `mcountinhibit`=0x5 → counters freeze from the cycle after the write;
  - write 0 → counting resumes;
  - readback of 0xFFFF_FFFF written returns 0x5.
- **Illegal accesses:** write 0xC00, read 0x123, and (XLEN=64) read 0xC80 → each gives `CsrIllegal`=1 and `CsrReadData`=0, with counters unaffected.
